// File: rtl/bcrypt_pkg.sv
// Shared constants and types for the bcrypt output path.
// Field offsets, index boundaries and the encoder state enum.
package bcrypt_pkg;

  localparam int CHAR_COUNT = 60;
  localparam int SALT_CHARS = 22;
  localparam int HASH_CHARS = 31;

  localparam logic [5:0] SALT_IDX = 6'd7;
  localparam logic [5:0] HASH_IDX = 6'd29;
  localparam logic [5:0] LAST_IDX = 6'(CHAR_COUNT - 1);

  localparam logic [7:0] MIN_COST = 8'd4;
  localparam logic [7:0] MAX_COST = 8'd31;

  localparam int COST_LSB = 320;
  localparam int SALT_LSB = 192;

  // salt + hash chunks held in one shift register
  localparam int SR_W = 6 * (SALT_CHARS + HASH_CHARS);

  typedef enum logic [1:0] {
    IDLE,
    REJECT,
    EMIT
  } state_t;

endpackage

// File: rtl/bcrypt_b64_char.sv
// bcrypt radix-64 alphabet: 6-bit value to ASCII.
// Order is "./", "A".."Z", "a".."z", "0".."9".
module bcrypt_b64_char (
  input  logic [5:0] v,
  output logic [7:0] c
);

  logic [7:0] v8;

  assign v8 = {2'b00, v};

  // map each alphabet range with a constant offset
  always_comb begin
    c = 8'h00;
    unique case (1'b1)
      (v == 6'd0):                c = 8'h2e;
      (v == 6'd1):                c = 8'h2f;
      (v >= 6'd2 && v <= 6'd27):  c = v8 + 8'h3f;
      (v >= 6'd28 && v <= 6'd53): c = v8 + 8'h45;
      (v >= 6'd54):               c = v8 - 8'h06;
      default:                    c = 8'h00;
    endcase
  end

endmodule

// File: rtl/bcrypt_radix64_encoder.sv
// Streams "$2a$CC$<salt><hash>" as ASCII, one char per handshake.
// Salt/hash chunks come from a 6-bit-per-char shift register.
module bcrypt_radix64_encoder
  import bcrypt_pkg::*;
#(
  parameter logic [7:0] VERSION_CHAR = 8'h61
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [327:0] cryptm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_char,
  output logic [5:0]   out_idx,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  state_t state, nstate;

  logic [5:0]      idx;
  logic [7:0]      cost;
  logic [SR_W-1:0] sr;

  logic [7:0] in_cost;
  logic       cost_ok;
  logic       in_hs;
  logic       out_hs;
  logic [7:0] tens_ch;
  logic [7:0] ones;
  logic [7:0] b64_ch;
  logic [7:0] ch;
  logic       unused_bits;

  assign in_cost = cryptm[COST_LSB +: 8];
  assign cost_ok = (in_cost >= MIN_COST) &&
                   (in_cost <= MAX_COST);
  assign in_hs   = (state == IDLE) && in_valid;
  assign out_hs  = (state == EMIT) && out_ready;

  // last hash byte never reaches the string
  assign unused_bits = ^cryptm[7:0];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (in_valid) nstate = cost_ok ? EMIT : REJECT;
      end
      REJECT: nstate = IDLE;
      EMIT: begin
        if (out_ready && idx == LAST_IDX) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // latch result on accept, advance index/shift on each char
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      cost <= '0;
      sr   <= '0;
    end else if (in_hs) begin
      idx  <= '0;
      cost <= in_cost;
      sr   <= {cryptm[SALT_LSB +: 128], 4'b0000,
               cryptm[191:8], 2'b00};
    end else if (out_hs) begin
      idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
      if (idx >= SALT_IDX) sr <= {sr[SR_W-7:0], 6'b0};
    end
  end

  // decimal cost digits by compare chain
  always_comb begin
    tens_ch = 8'h30;
    ones    = cost;
    unique case (1'b1)
      (cost >= 8'd30): begin
        tens_ch = 8'h33;
        ones    = cost - 8'd30;
      end
      (cost >= 8'd20 && cost < 8'd30): begin
        tens_ch = 8'h32;
        ones    = cost - 8'd20;
      end
      (cost >= 8'd10 && cost < 8'd20): begin
        tens_ch = 8'h31;
        ones    = cost - 8'd10;
      end
      default: ;
    endcase
  end

  bcrypt_b64_char u_b64 (
    .v (sr[SR_W-1 -: 6]),
    .c (b64_ch)
  );

  // character select by position
  always_comb begin
    ch = 8'h00;
    unique case (1'b1)
      (idx == 6'd0 || idx == 6'd3 || idx == 6'd6):
        ch = 8'h24;
      (idx == 6'd1): ch = 8'h32;
      (idx == 6'd2): ch = VERSION_CHAR;
      (idx == 6'd4): ch = tens_ch;
      (idx == 6'd5): ch = 8'h30 + ones;
      (idx >= SALT_IDX): ch = b64_ch;
      default: ch = 8'h00;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign err       = (state == REJECT);
  assign out_valid = (state == EMIT);
  assign out_char  = out_valid ? ch : 8'h00;
  assign out_idx   = out_valid ? idx : 6'd0;
  assign out_last  = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_bcrypt_radix64_encoder.sv
// Directed bench for bcrypt_radix64_encoder.
// Samples on negedge, drives on negedge.
module tb_bcrypt_radix64_encoder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [327:0] cryptm;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic [5:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         err;

  int n_assert;
  int n_fail;
  logic [7:0] got [60];

  bcrypt_radix64_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cryptm    (cryptm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_char(
    input logic [7:0]   cost,
    input logic [127:0] salt,
    input logic [191:0] hash,
    input int           i
  );
    string alpha;
    logic [131:0] sp;
    logic [185:0] hp;
    logic [5:0] v;
    alpha = "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
    sp = {salt, 4'b0};
    hp = {hash[191:8], 2'b0};
    if (i == 0 || i == 3 || i == 6) return 8'h24;
    if (i == 1) return 8'h32;
    if (i == 2) return 8'h61;
    if (i == 4) return 8'h30 + 8'(cost / 10);
    if (i == 5) return 8'h30 + 8'(cost % 10);
    if (i < 29) v = sp[131 - 6*(i-7) -: 6];
    else        v = hp[185 - 6*(i-29) -: 6];
    return alpha[int'(v)];
  endfunction

  task automatic send(input logic [7:0] cost,
                      input logic [127:0] salt,
                      input logic [191:0] hash);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_in_ready got=%b want=1", in_ready);
    end
    cryptm   = {cost, salt, hash};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cryptm   = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom};
  endtask

  task automatic collect(input logic [7:0] cost,
                         input logic [127:0] salt,
                         input logic [191:0] hash,
                         input bit rnd);
    int cnt, cyc;
    bit stalled, rdy;
    logic [7:0] s_ch;
    logic [5:0] s_idx;
    logic s_last;
    logic [7:0] e;
    cnt = 0; cyc = 0; stalled = 0;
    s_ch = 0; s_idx = 0; s_last = 0;
    while (cnt < 60 && cyc < 1000) begin
      n_assert++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL valid idx=%0d got=%b want=1", cnt, out_valid);
      end
      if (stalled) begin
        n_assert++;
        if (out_char !== s_ch || out_idx !== s_idx ||
            out_last !== s_last) begin
          n_fail++;
          $display("FAIL stall_hold got=%h/%0d/%b want=%h/%0d/%b",
                   out_char, out_idx, out_last, s_ch, s_idx, s_last);
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        e = exp_char(cost, salt, hash, cnt);
        got[cnt] = out_char;
        n_assert++;
        if (out_char !== e || out_idx !== 6'(cnt) ||
            out_last !== (cnt == 59)) begin
          n_fail++;
          $display("FAIL char idx=%0d got=%h/%0d/%b want=%h/%0d/%b",
                   cnt, out_char, out_idx, out_last,
                   e, cnt, (cnt == 59));
        end
        cnt++;
        stalled = 0;
      end else begin
        s_ch = out_char; s_idx = out_idx; s_last = out_last;
        stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_assert++;
    if (cnt != 60) begin
      n_fail++;
      $display("FAIL timeout chars=%0d want=60", cnt);
    end
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_string rdy/val/busy got=%b%b%b want=100",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if (in_ready !== 1 || out_valid !== 0 || out_char !== 0 ||
        out_idx !== 0 || out_last !== 0 || busy !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL reset got=%b%b%h%0d%b%b%b want=1000000",
               in_ready, out_valid, out_char, out_idx,
               out_last, busy, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send(8'd5, '0, '0);
    collect(8'd5, '0, '0, 0);
    n_assert++;
    if (got[4] !== 8'h30 || got[5] !== 8'h35 || got[59] !== 8'h2e) begin
      n_fail++;
      $display("FAIL basic_spot got=%h%h%h want=30352e",
               got[4], got[5], got[59]);
    end
  endtask

  task automatic test_salt;
    send(8'd12, 128'd32, '0);
    collect(8'd12, 128'd32, '0, 0);
    n_assert++;
    if (got[27] !== 8'h47 || got[26] !== 8'h2e || got[28] !== 8'h2e ||
        got[4] !== 8'h31 || got[5] !== 8'h32) begin
      n_fail++;
      $display("FAIL salt_spot got=%h %h %h %h%h want=47 2e 2e 3132",
               got[27], got[26], got[28], got[4], got[5]);
    end
  endtask

  task automatic test_ones;
    send(8'd31, '1, '1);
    collect(8'd31, '1, '1, 0);
    n_assert++;
    if (got[7] !== 8'h39 || got[27] !== 8'h39 || got[28] !== 8'h75 ||
        got[29] !== 8'h39 || got[58] !== 8'h39 || got[59] !== 8'h36 ||
        got[4] !== 8'h33 || got[5] !== 8'h31) begin
      n_fail++;
      $display("FAIL ones_spot got=%h %h %h %h %h %h %h%h",
               got[7], got[27], got[28], got[29], got[58], got[59],
               got[4], got[5]);
    end
  endtask

  task automatic test_reject;
    logic [7:0] bad [3];
    bad[0] = 8'd3; bad[1] = 8'd32; bad[2] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      send(bad[i], '1, '1);
      n_assert++;
      if (err !== 1 || out_valid !== 0 || in_ready !== 0) begin
        n_fail++;
        $display("FAIL reject1 cost=%0d err/val/rdy got=%b%b%b want=100",
                 bad[i], err, out_valid, in_ready);
      end
      @(negedge clk);
      n_assert++;
      if (err !== 0 || out_valid !== 0 || in_ready !== 1) begin
        n_fail++;
        $display("FAIL reject2 cost=%0d err/val/rdy got=%b%b%b want=001",
                 bad[i], err, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] s;
    logic [191:0] h;
    s = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    h = 192'hdead_beef_cafe_f00d_1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978;
    send(8'd10, s, h);
    collect(8'd10, s, h, 1);
    send(8'd10, s, h);
    collect(8'd10, s, h, 1);
  endtask

  task automatic test_mid_reset;
    int k;
    send(8'd12, 128'd32, '0);
    out_ready = 1'b1;
    k = 0;
    while (out_idx !== 6'd30 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    if (out_idx !== 6'd30) begin
      n_fail++;
      $display("FAIL midrst_reach got=%0d want=30", out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    n_assert++;
    if (out_valid !== 0 || in_ready !== 1 || out_idx !== 0 ||
        out_last !== 0 || busy !== 0 || out_char !== 0) begin
      n_fail++;
      $display("FAIL midrst val/rdy/idx/last/busy/ch got=%b%b%0d%b%b%h want=010000",
               out_valid, in_ready, out_idx, out_last, busy, out_char);
    end
    send(8'd7, '1, '0);
    collect(8'd7, '1, '0, 0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cryptm    = '0;
    test_reset();
    test_basic();
    test_salt();
    test_ones();
    test_reject();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
